// File: rtl/ser_pkg.sv
// Shared types and defaults for the bit serializer.
// Optional parity frame bit is enabled with BIT_SERIALIZER_PARITY_EN.
package ser_pkg;

   localparam int SER_WIDTH_DEF = 8;
   localparam int SER_DIV_DEF   = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
`ifdef BIT_SERIALIZER_PARITY_EN
      ST_PARITY = 2'd2,
`endif
      ST_DONE   = 2'd3
   } ser_state_e;

   function automatic logic even_parity(input logic [31:0] i_word);
      return ^i_word;
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-load handshake and serial output bundle for bit_serializer.
interface bit_serializer_if
   import ser_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH_DEF
);
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;
   logic             data;
   logic             select;
   logic             busy;
   logic             done;

   modport master (
      output load_valid, load_data,
      input  load_ready, data, select, busy, done
   );

   modport slave (
      input  load_valid, load_data,
      output load_ready, data, select, busy, done
   );
endinterface

// File: rtl/bit_period_counter.sv
// Bit-period divider: tick marks the last clock of each DIV-cycle period,
// start restarts the period. DIV=1 bypasses the counter entirely.
module bit_period_counter
   import ser_pkg::*;
#(
   parameter int DIV = SER_DIV_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic tick
);
   generate
      if (DIV == 1) begin : g_bypass
         logic w_unused;
         assign w_unused = ^{clk, reset, start};
         assign tick     = 1'b1;
      end else begin : g_count
         localparam logic [7:0] LAST = 8'(DIV - 1);
         logic [7:0] r_cnt;

         // Period position counter, wraps at DIV-1 and restarts on start.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_cnt <= 8'd0;
            end else if (start || (r_cnt == LAST)) begin
               r_cnt <= 8'd0;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end

         assign tick = (r_cnt == LAST);
      end
   endgenerate
endmodule

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with per-bit strobe and done pulse.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module bit_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH_DEF,
   parameter int DIV   = SER_DIV_DEF
) (
   input  logic            clk,
   input  logic            reset,
   bit_serializer_if.slave bus
);
   localparam int             BCW      = $clog2(WIDTH + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

   ser_state_e       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_shift, w_shift_nxt;
   logic [BCW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
   logic             w_hs, w_tick;
   logic             w_data_nxt, w_select_nxt, w_busy_nxt;
   logic             r_data, r_select, r_busy, r_done;
`ifdef BIT_SERIALIZER_PARITY_EN
   logic             r_parity;
`endif

   assign bus.load_ready = (r_state == ST_IDLE) && !reset;
   assign w_hs           = bus.load_valid && bus.load_ready;

   bit_period_counter #(.DIV(DIV)) u_period (
      .clk   (clk),
      .reset (reset),
      .start (w_hs),
      .tick  (w_tick)
   );

   // Next-state, shift and bit-count logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_hs) begin
               w_state_nxt   = ST_SHIFT;
               w_shift_nxt   = bus.load_data;
               w_bit_cnt_nxt = BCW'(0);
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (w_tick) begin
               w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
               if (r_bit_cnt == LAST_BIT) begin
                  w_bit_cnt_nxt = BCW'(0);
`ifdef BIT_SERIALIZER_PARITY_EN
                  w_state_nxt   = ST_PARITY;
`else
                  w_state_nxt   = ST_DONE;
`endif
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
               end
            end else begin
               w_state_nxt = ST_SHIFT;
            end
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         ST_PARITY: begin
            if (w_tick) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_PARITY;
            end
         end
`endif
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output values for the coming cycle, registered below.
   always_comb begin
      w_data_nxt = 1'b0;
      w_busy_nxt = 1'b0;
      case (w_state_nxt)
         ST_SHIFT: begin
            w_data_nxt = w_shift_nxt[WIDTH-1];
            w_busy_nxt = 1'b1;
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         ST_PARITY: begin
            w_data_nxt = r_parity;
            w_busy_nxt = 1'b1;
         end
`endif
         default: begin
            w_data_nxt = 1'b0;
            w_busy_nxt = 1'b0;
         end
      endcase
      w_select_nxt = w_busy_nxt && (w_hs || w_tick);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= BCW'(0);
         r_data    <= 1'b0;
         r_select  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_data    <= w_data_nxt;
         r_select  <= w_select_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= (w_state_nxt == ST_DONE);
      end
   end

`ifdef BIT_SERIALIZER_PARITY_EN
   // Parity of the captured word, fixed for the whole frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_parity <= 1'b0;
      end else if (w_hs) begin
         r_parity <= even_parity(32'(bus.load_data));
      end else begin
         r_parity <= r_parity;
      end
   end
`endif

   assign bus.data   = r_data;
   assign bus.select = r_select;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
endmodule

// File: tb/tb_bit_serializer.sv
// Randomized bench for bit_serializer (DIV=1 and DIV=3 instances) against a
// frame-queue reference model, plus literal checks of key frame timings.
module tb_bit_serializer;
   localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam logic [3:0] IDLE_E = 4'b0000;

   logic         clk        = 1'b0;
   logic         reset      = 1'b1;
   logic         load_valid = 1'b0;
   logic [W-1:0] load_data  = '0;
   int           pass_cnt   = 0;
   int           total_cnt  = 0;

   // Expected {data, select, busy, done} per future cycle, per instance.
   logic [3:0] q [2][$];
   logic [3:0] cur [2] = '{4'b0000, 4'b0000};
   logic [4:0] act [2];

   always #5 clk = ~clk;

   bit_serializer_if #(.WIDTH(W)) bif0 ();
   bit_serializer_if #(.WIDTH(W)) bif1 ();

   assign bif0.load_valid = load_valid;
   assign bif0.load_data  = load_data;
   assign bif1.load_valid = load_valid;
   assign bif1.load_data  = load_data;

   bit_serializer #(.WIDTH(W), .DIV(1)) u_dut0 (.clk(clk), .reset(reset), .bus(bif0));
   bit_serializer #(.WIDTH(W), .DIV(3)) u_dut1 (.clk(clk), .reset(reset), .bus(bif1));

   assign act[0] = {bif0.load_ready, bif0.data, bif0.select, bif0.busy, bif0.done};
   assign act[1] = {bif1.load_ready, bif1.data, bif1.select, bif1.busy, bif1.done};

   function automatic int div_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Reference model: a handshake in idle enqueues the whole frame's cycles.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            q[d].delete();
            cur[d] = IDLE_E;
         end else begin
            if (load_valid && (cur[d] == IDLE_E)) begin
               for (int i = W - 1; i >= 0; i--)
                  for (int j = 0; j < div_of(d); j++)
                     q[d].push_back({load_data[i], (j == 0), 1'b1, 1'b0});
               if (PAR == 1)
                  for (int j = 0; j < div_of(d); j++)
                     q[d].push_back({^load_data, (j == 0), 1'b1, 1'b0});
               q[d].push_back(4'b0001);
            end
            cur[d] = (q[d].size() > 0) ? q[d].pop_front() : IDLE_E;
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++)
         check($sformatf("cycle_div%0d", div_of(d)), 32'(act[d]),
               32'({(!reset && (cur[d] == IDLE_E)), cur[d]}));
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(bif0.load_ready && bif1.load_ready) && n < 80) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", 32'(bif0.load_ready && bif1.load_ready), 32'd1);
   endtask

   task automatic frame(input logic [7:0] w, output int done0, output int done1,
                        output int ready0, output logic [8:0] bits0, output int strobes1,
                        output logic [2:0] d1_first, output logic [3:0] sel1_first);
      done0 = 0; done1 = 0; ready0 = 0; bits0 = '0; strobes1 = 0;
      d1_first = '0; sel1_first = '0;
      wait_idle();
      @(posedge clk); #1;
      load_valid = 1'b1;
      load_data  = w;
      @(posedge clk); #1;
      load_valid = 1'b0;
      load_data  = 8'($urandom);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bif0.done && done0 == 0) done0 = n;
         if (bif1.done && done1 == 0) done1 = n;
         if (done0 != 0 && ready0 == 0 && bif0.load_ready) ready0 = n;
         if (bif0.select) bits0 = {bits0[7:0], bif0.data};
         if (bif1.select) strobes1++;
         if (n <= 3) d1_first = {d1_first[1:0], bif1.data};
         if (n <= 4) sel1_first = {sel1_first[2:0], bif1.select};
      end
   endtask

   initial begin
      int         d0, d1, r0, s1;
      logic [8:0] b0;
      logic [2:0] f1;
      logic [3:0] g1;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_state_div1", 32'(act[0]), 32'h10);
      check("reset_state_div3", 32'(act[1]), 32'h10);

      frame(8'hA5, d0, d1, r0, b0, s1, f1, g1);
      check("a5_done_cycle", 32'(d0), 32'(9 + PAR));
      check("a5_ready_cycle", 32'(r0), 32'(10 + PAR));
      check("a5_bits", 32'(b0), (PAR == 1) ? 32'h14A : 32'h0A5);

      frame(8'h81, d0, d1, r0, b0, s1, f1, g1);
      check("81_div3_done_cycle", 32'(d1), 32'(25 + 3 * PAR));
      check("81_div3_strobes", 32'(s1), 32'(8 + PAR));
      check("81_div3_first_bit", 32'(f1), 32'h7);
      check("81_div3_first_selects", 32'(g1), 32'h9);

      frame(8'h07, d0, d1, r0, b0, s1, f1, g1);
      check("07_done_cycle", 32'(d0), 32'(9 + PAR));
      check("07_bits", 32'(b0), (PAR == 1) ? 32'h00F : 32'h007);

      // Reset during cycle k+4 of an 8'hFF frame.
      wait_idle();
      @(posedge clk); #1;
      load_valid = 1'b1;
      load_data  = 8'hFF;
      @(posedge clk); #1;
      load_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midframe_reset_div1", 32'(act[0]), 32'h10);
      check("midframe_reset_div3", 32'(act[1]), 32'h10);

      // Reset and load_valid together: no capture.
      @(posedge clk); #1;
      reset      = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'h3C;
      @(posedge clk); #1;
      reset      = 1'b0;
      load_valid = 1'b0;
      @(negedge clk);
      check("reset_vs_load_div1", 32'(act[0]), 32'h10);
      check("reset_vs_load_div3", 32'(act[1]), 32'h10);

      // load_valid held high with data changing every cycle.
      wait_idle();
      @(posedge clk); #1;
      load_valid = 1'b1;
      repeat (80) begin
         load_data = 8'($urandom);
         @(posedge clk); #1;
      end
      load_valid = 1'b0;

      repeat (700) begin
         @(posedge clk); #1;
         load_valid = 1'($urandom_range(0, 1));
         load_data  = 8'($urandom);
         reset      = ($urandom_range(0, 63) == 0);
      end
      @(posedge clk); #1;
      reset      = 1'b0;
      load_valid = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length in bits (legal range 2..32).
REQ-002 SHALL have parameter DIV, default 1, clock cycles per serial bit period (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_valid  input  1  parallel word offered.
REQ-006 SHALL have port load_data  input  WIDTH  parallel word, sampled only on handshake.
REQ-007 SHALL have port load_ready  output  1  serializer can accept a word.
REQ-008 SHALL have port data  output  1  serial bit, MSB first, held for the whole bit period.
REQ-009 SHALL have port select  output  1  one-cycle strobe in the first cycle of each bit period; the capturing hold-flop loads data when select=1.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, PARITY, DONE.
REQ-013 SHALL drive load_ready = 1 only in IDLE with reset low; combinational from state.
REQ-014 SHALL accept a word on the edge where load_valid && load_ready; load_valid while load_ready=0 is ignored, with no queueing.
REQ-015 SHALL, handshake at edge k, enter SHIFT and present data=load_data[WIDTH-1] with select=1 and busy=1 in cycle k+1.
REQ-016 SHALL hold each bit for exactly DIV cycles, with select high only in the first of them; bit i (MSB=0) starts at cycle k+1+i*DIV.
REQ-017 SHALL shift the captured word internally; load_data changes after handshake SHALL NOT affect the frame.
REQ-018 SHALL, after the last data bit period, go to PARITY if enabled (REQ-026), else to DONE.
REQ-019 SHALL in DONE assert done=1 for one cycle with data=0, select=0, busy=0; the next state is IDLE.
REQ-020 SHALL drive data=0 and select=0 whenever not in SHIFT/PARITY.
REQ-021 SHALL have a frame length of WIDTH*DIV cycles (plus DIV with parity) plus 1 DONE cycle; back-to-back: next handshake earliest at the edge after DONE.
REQ-022 SHALL count bits with a log2(WIDTH+1)-bit counter and bit periods with an 8-bit counter; with DIV=1 the period counter is bypassed and select is high every SHIFT cycle.

Reset
REQ-023 SHALL, with reset high at an edge, force state=IDLE, data=0, select=0, busy=0, done=0 and clear the shift register and counters.
REQ-024 SHALL, on reset mid-frame, abort the frame with no done pulse; load_ready=1 is restored the first cycle reset is low.
REQ-025 SHALL give reset priority over a simultaneous handshake.

Configuration
REQ-026 SHALL, with BIT_SERIALIZER_PARITY_EN defined, append one even-parity bit (XOR of the captured word) for DIV cycles with select=1 in its first cycle, in state PARITY.
REQ-027 SHALL, without BIT_SERIALIZER_PARITY_EN, omit the PARITY state and parity logic entirely, so that SHIFT transitions directly to DONE.

Structure
REQ-028 SHALL place the state enum typedef and the WIDTH/DIV default constants in shared package ser_pkg.
REQ-029 SHALL implement the bit-period divider as sub-module bit_period_counter (inputs clk, reset, start; output tick).

Verification
REQ-030 SHALL cover: WIDTH=8, DIV=1, load 8'hA5 -> select=1 for cycles k+1..k+8, data=1,0,1,0,0,1,0,1, done at k+9, load_ready at k+10.
REQ-031 SHALL cover: DIV=3, load 8'h81 -> data=1 for cycles k+1..k+3, select only at k+1,k+4,...,k+22, done at k+25.
REQ-032 SHALL cover: load_valid held high with load_data changing during a frame -> no second capture until after done; the second word is serialized intact.
REQ-033 SHALL cover: reset pulsed at cycle k+4 of an 8'hFF frame -> data=0, busy=0 next cycle, no done, load_ready=1 once reset drops.
REQ-034 SHALL cover: with BIT_SERIALIZER_PARITY_EN, load 8'h07 -> 9th strobed bit = 1, done at k+10; without the macro, done at k+9.
REQ-035 SHALL cover: reset and load_valid asserted in the same cycle -> word not accepted, outputs at reset values.
